rr_mux_arbiter: RTL and testbench

Round-robin arbiter that shares the 16-input, 16-bit datapath multiplexer (`mux16_1`) among 16 requesters. It converts a request vector into a registered 4-bit select plus enable for the mux and a one-hot grant back to the requesters. Each grant is held until the owner releases it or a programmable hold limit expires. It sits between the requesting units and the mux select/enable pins; the mux data path itself is untouched.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/rr_mux_arbiter_if.sv | 24 ++
 rtl/rr_pick16.sv | 36 +++
 rtl/rr_mux_arbiter.sv | 88 ++++++++
 tb/tb_rr_mux_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state type and helpers for the round-robin mux arbiter
package arb_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    localparam int MAX_HOLD_MIN = 1;
    localparam int MAX_HOLD_MAX = 255;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Width of a counter that must reach max_hold-1; never narrower than one bit.
    function automatic int cnt_width(input int max_hold);
        return (max_hold > 2) ? $clog2(max_hold) : 1;
    endfunction

    // One-hot vector with bit idx set.
    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// rtl/rr_mux_arbiter_if.sv - request/grant and mux control bundle between requesters and arbiter
interface rr_mux_arbiter_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             busy;
    logic             timeout;

    // Requester / integration side.
    modport master (
        output req,
        input  gnt, sel, en, busy, timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        output gnt, sel, en, busy, timeout
    );

endinterface

// File: rtl/rr_pick16.sv
// rtl/rr_pick16.sv - combinational round-robin pick: first request after ptr, wrapping 15 -> 0
module rr_pick16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             found_o,
    output logic [SEL_W-1:0] idx_o
);

    logic [SEL_W:0]       shift;
    logic [2*N_REQ-1:0]   doubled;
    logic [N_REQ-1:0]     rotated;
    logic [SEL_W-1:0]     offset;

    // Rotate so that bit ptr+1 lands at position 0; a shift of 16 is a full turn.
    assign shift   = {1'b0, ptr_i} + 5'd1;
    assign doubled = {req_i, req_i} >> shift;
    assign rotated = doubled[N_REQ-1:0];

    // Lowest set bit of the rotated vector is the nearest requester after ptr.
    always_comb begin
        found_o = 1'b0;
        offset  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found_o = 1'b1;
                offset  = i[SEL_W-1:0];
            end
        end
    end

    // Undo the rotation; the 4-bit add wraps modulo 16.
    assign idx_o = ptr_i + 4'd1 + offset;

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter driving the shared mux16_1 select/enable with hold limit
module rr_mux_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux_arbiter_if.slave    bus
);

    localparam int             CNT_W    = cnt_width(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    if (MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_max_hold
        $error("rr_mux_arbiter: MAX_HOLD must be within 1..255");
    end

    arb_state_e        state_q;
    logic [SEL_W-1:0]  ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_REQ-1:0]  gnt_q;
    logic              en_q;
    logic              timeout_q;

    logic              pick_found_d;
    logic [SEL_W-1:0]  pick_idx_d;

    rr_pick16 u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .found_o (pick_found_d),
        .idx_o   (pick_idx_d)
    );

    // Arbitration FSM: all outputs registered; timeout is a single-cycle pulse after a forced revoke.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 4'hF;
            cnt_q     <= '0;
            gnt_q     <= '0;
            en_q      <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_found_d) begin
                        state_q <= BUSY;
                        ptr_q   <= pick_idx_d;
                        gnt_q   <= onehot(pick_idx_d);
                        en_q    <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                BUSY: begin
                    if (!bus.req[ptr_q]) begin
                        // Voluntary release wins over a coincident hold expiry.
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        en_q    <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        gnt_q     <= '0;
                        en_q      <= 1'b0;
                        timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    // sel tracks the last winner so the mux select is stable while disabled.
    assign bus.gnt     = gnt_q;
    assign bus.sel     = ptr_q;
    assign bus.en      = en_q;
    assign bus.busy    = en_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb/tb_rr_mux_arbiter.sv - scoreboard bench for rr_mux_arbiter with MAX_HOLD 8 and 4 instances
module tb_rr_mux_arbiter;

    typedef struct packed {
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        en;
        logic        to;
        logic [7:0]  tag;
    } exp_t;

    logic clk;
    logic rst8;
    logic rst4;

    rr_mux_arbiter_if if8 ();
    rr_mux_arbiter_if if4 ();

    rr_mux_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (if8)
    );

    rr_mux_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (if4)
    );

    exp_t q8[$];
    exp_t q4[$];
    int   checks_total;
    int   checks_passed;
    bit   stim_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive8(input logic r, input logic [15:0] rq, input logic [15:0] g,
                          input logic [3:0] s, input logic e, input logic t, input logic [7:0] tag);
        exp_t x;
        @(negedge clk);
        rst8    = r;
        if8.req = rq;
        x.gnt = g; x.sel = s; x.en = e; x.to = t; x.tag = tag;
        q8.push_back(x);
    endtask

    task automatic drive4(input logic r, input logic [15:0] rq, input logic [15:0] g,
                          input logic [3:0] s, input logic e, input logic t, input logic [7:0] tag);
        exp_t x;
        @(negedge clk);
        rst4    = r;
        if4.req = rq;
        x.gnt = g; x.sel = s; x.en = e; x.to = t; x.tag = tag;
        q4.push_back(x);
    endtask

    // Monitor: every output cycle with a pending expectation is popped and compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                checks_total++;
                if (if8.gnt !== e.gnt || if8.sel !== e.sel || if8.en !== e.en ||
                    if8.busy !== e.en || if8.timeout !== e.to)
                    $display("FAIL dut8 tag=%0d got gnt=%h sel=%h en=%b busy=%b to=%b need gnt=%h sel=%h en=%b busy=%b to=%b",
                             e.tag, if8.gnt, if8.sel, if8.en, if8.busy, if8.timeout,
                             e.gnt, e.sel, e.en, e.en, e.to);
                else
                    checks_passed++;
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                checks_total++;
                if (if4.gnt !== e.gnt || if4.sel !== e.sel || if4.en !== e.en ||
                    if4.busy !== e.en || if4.timeout !== e.to)
                    $display("FAIL dut4 tag=%0d got gnt=%h sel=%h en=%b busy=%b to=%b need gnt=%h sel=%h en=%b busy=%b to=%b",
                             e.tag, if4.gnt, if4.sel, if4.en, if4.busy, if4.timeout,
                             e.gnt, e.sel, e.en, e.en, e.to);
                else
                    checks_passed++;
            end
        end
    end

    // Stimulus with hand-computed expectations.
    initial begin
        logic [3:0]  w;
        logic [15:0] oh;
        checks_total  = 0;
        checks_passed = 0;
        stim_done     = 1'b0;
        rst8 = 1'b1; rst4 = 1'b1;
        if8.req = 16'h0000; if4.req = 16'h0000;

        // Reset with all requesting, then first grant goes to 0 (ptr=15 -> search from 0).
        drive8(1, 16'hFFFF, 16'h0000, 4'hF, 0, 0, 1);
        drive8(1, 16'hFFFF, 16'h0000, 4'hF, 0, 0, 2);
        drive8(0, 16'hFFFF, 16'h0001, 4'h0, 1, 0, 3);
        drive8(0, 16'h0000, 16'h0000, 4'h0, 0, 0, 4);

        // Single requester held 3 cycles.
        drive8(0, 16'h0001, 16'h0001, 4'h0, 1, 0, 10);
        drive8(0, 16'h0001, 16'h0001, 4'h0, 1, 0, 11);
        drive8(0, 16'h0001, 16'h0001, 4'h0, 1, 0, 12);
        drive8(0, 16'h0000, 16'h0000, 4'h0, 0, 0, 13);
        drive8(0, 16'h0000, 16'h0000, 4'h0, 0, 0, 14);

        // Wrap-around: after 5, request 0|5 picks 0, then 5.
        drive8(0, 16'h0020, 16'h0020, 4'h5, 1, 0, 20);
        drive8(0, 16'h0000, 16'h0000, 4'h5, 0, 0, 21);
        drive8(0, 16'h0021, 16'h0001, 4'h0, 1, 0, 22);
        drive8(0, 16'h0020, 16'h0000, 4'h0, 0, 0, 23);
        drive8(0, 16'h0020, 16'h0020, 4'h5, 1, 0, 24);
        drive8(0, 16'h0000, 16'h0000, 4'h5, 0, 0, 25);

        // Reset mid-grant on requester 9 at cnt=2; regrant after reset.
        drive8(0, 16'h0200, 16'h0200, 4'h9, 1, 0, 30);
        drive8(0, 16'h0200, 16'h0200, 4'h9, 1, 0, 31);
        drive8(0, 16'h0200, 16'h0200, 4'h9, 1, 0, 32);
        drive8(1, 16'h0200, 16'h0000, 4'hF, 0, 0, 33);
        drive8(0, 16'h0200, 16'h0200, 4'h9, 1, 0, 34);
        drive8(0, 16'h0000, 16'h0000, 4'h9, 0, 0, 35);

        // Forced revoke at MAX_HOLD=8, then regrant of the same lone requester.
        for (int c = 0; c < 8; c++)
            drive8(0, 16'h0400, 16'h0400, 4'hA, 1, 0, 8'(40 + c));
        drive8(0, 16'h0400, 16'h0000, 4'hA, 0, 1, 48);
        drive8(0, 16'h0400, 16'h0400, 4'hA, 1, 0, 49);
        drive8(0, 16'h0000, 16'h0000, 4'hA, 0, 0, 50);

        // MAX_HOLD=4 instance: saturation 0..15,0, each 4 busy + 1 timeout cycle.
        drive4(1, 16'h0000, 16'h0000, 4'hF, 0, 0, 60);
        for (int g = 0; g < 17; g++) begin
            w  = 4'(g % 16);
            oh = 16'h0001 << w;
            for (int c = 0; c < 4; c++)
                drive4(0, 16'hFFFF, oh, w, 1, 0, 8'(g));
            drive4(0, 16'hFFFF, 16'h0000, w, 0, 1, 8'(100 + g));
        end
        drive4(0, 16'h0000, 16'h0000, 4'h0, 0, 0, 61);

        // Release coinciding with hold expiry is a plain release.
        drive4(0, 16'h0002, 16'h0002, 4'h1, 1, 0, 70);
        drive4(0, 16'h0002, 16'h0002, 4'h1, 1, 0, 71);
        drive4(0, 16'h0002, 16'h0002, 4'h1, 1, 0, 72);
        drive4(0, 16'h0002, 16'h0002, 4'h1, 1, 0, 73);
        drive4(0, 16'h0000, 16'h0000, 4'h1, 0, 0, 74);
        drive4(0, 16'h0000, 16'h0000, 4'h1, 0, 0, 75);

        @(negedge clk);
        @(negedge clk);
        stim_done = 1'b1;
    end

    // Summary once stimulus and scoreboard have drained; bounded in time.
    initial begin
        fork
            wait (stim_done);
            #50000;
        join_any
        disable fork;
        @(negedge clk);
        if (!stim_done || q8.size() != 0 || q4.size() != 0) begin
            checks_total++;
            $display("FAIL drain done=%0b q8=%0d q4=%0d need done=1 q8=0 q4=0",
                     stim_done, q8.size(), q4.size());
        end
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
